// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of Data_memory: one request at a time,
// one memory cycle per request, registered response to the winning port.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    typedef enum logic {IDLE, ACCESS} state_e;

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;     // port that wins a tie next
    logic              lat_we_q, lat_we_d;
    logic              lat_port_q, lat_port_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic              rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d, rsp1_rdata_q, rsp1_rdata_d;

    logic              grant1;
    logic              handshake;
    logic              misaligned;
    logic [DATA_W-1:0] access_rdata;

    always_comb begin
        if (req0_valid && req1_valid) begin
            grant1 = (RR_EN != 0) ? rr_ptr_q : 1'b0;
        end else begin
            grant1 = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && !reset && req0_valid && !grant1;
    assign req1_ready = (state_q == IDLE) && !reset && req1_valid && grant1;
    assign handshake  = req0_ready || req1_ready;

    // The latched address doubles as the held mem_addr output.
    assign misaligned   = (mem_addr_q[2:0] != 3'b000);
    assign access_rdata = (lat_we_q || misaligned) ? '0 : mem_read_data;

    assign MemRead  = (state_q == ACCESS) && !lat_we_q && !misaligned;
    // A write whose ending edge sees reset must never reach the memory.
    assign MemWrite = (state_q == ACCESS) && lat_we_q && !misaligned && !reset;

    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign rsp0_valid     = rsp0_valid_q;
    assign rsp0_rdata     = rsp0_rdata_q;
    assign rsp0_err       = rsp0_err_q;
    assign rsp1_valid     = rsp1_valid_q;
    assign rsp1_rdata     = rsp1_rdata_q;
    assign rsp1_err       = rsp1_err_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lat_we_d     = lat_we_q;
        lat_port_d   = lat_port_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        rsp0_err_d   = rsp0_err_q;
        rsp1_err_d   = rsp1_err_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d     = ACCESS;
                    lat_port_d  = grant1;
                    lat_we_d    = grant1 ? req1_we : req0_we;
                    mem_addr_d  = grant1 ? req1_addr : req0_addr;
                    mem_wdata_d = grant1 ? req1_wdata : req0_wdata;
                    rr_ptr_d    = !grant1;
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (lat_port_q) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_rdata_d = access_rdata;
                    rsp1_err_d   = misaligned;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_rdata_d = access_rdata;
                    rsp0_err_d   = misaligned;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_port_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lat_we_q     <= lat_we_d;
            lat_port_q   <= lat_port_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp1_err_q   <= rsp1_err_d;
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer in front of Data_memory. Port 0 serves the pipeline load/store unit. Port 1 serves a debug/DMA loader. The block accepts one request at a time over a valid/ready handshake, drives MemRead/MemWrite/addr/write_data to the memory for exactly one cycle, and returns a registered response to the winning requester.

Parameters:
ADDR_W, 64, width of request and memory address.
DATA_W, 64, width of write/read data (doubleword).
RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request present
req0_we  in  1  port 0: 1 = write, 0 = read
req0_addr  in  ADDR_W  port 0 byte address
req0_wdata  in  DATA_W  port 0 write data
req0_ready  out  1  port 0 request accepted this cycle
rsp0_valid  out  1  port 0 response pulse
rsp0_rdata  out  DATA_W  port 0 read data
rsp0_err  out  1  port 0 misaligned-address error
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err  same as port 0, for port 1
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
mem_addr  out  ADDR_W  memory byte address
mem_write_data  out  DATA_W  memory write data
mem_read_data  in  DATA_W  memory read data, combinational from mem_addr while MemRead=1

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- States:
  - IDLE: no access in flight.
  - ACCESS: one memory cycle for the latched request.
- Reset values: state=IDLE; reqN_ready=0; rspN_valid=0; rspN_rdata=0; rspN_err=0; MemRead=0; MemWrite=0; mem_addr=0; mem_write_data=0; round-robin pointer favours port 0.
- IDLE:
  - If any reqN_valid, choose winner and assert reqN_ready for the winner only. This is combinational from state and valids.
  - Handshake completes when valid&ready. At that edge, latch we/addr/wdata/port id and go to ACCESS.
- Arbitration:
  - RR_EN=1: on simultaneous valids, grant the port not granted last. Pointer updates on each handshake.
  - RR_EN=0: port 0 always wins.
- ACCESS (exactly 1 cycle):
  - Drive mem_addr and mem_write_data from the latched request.
  - Assert MemWrite=we or MemRead=!we.
  - Memory write commits on the ACCESS-ending edge.
  - On that same edge, capture mem_read_data for reads, or 0 for writes, into rspN_rdata.
  - Next state is IDLE. Both ready signals are 0 during ACCESS.
- Response:
  - rspN_valid is high for exactly the one cycle after ACCESS, only for the owning port.
  - rspN_rdata and rspN_err hold until the next response to that port.
  - The new-request check in IDLE overlaps the response cycle. Throughput is 1 transaction per 2 cycles. Request-to-response latency is 2 cycles.
- Outside ACCESS: MemRead=MemWrite=0. mem_addr and mem_write_data hold their last values.
- Misalignment (addr[2:0]!=0): the request is still accepted and enters ACCESS. MemRead and MemWrite stay 0, no memory change occurs. Response has err=1 and rdata=0.
- Requester rules: a requester holds valid and payload stable until it sees ready. Deasserting valid before ready is legal and withdraws the request.
- Reset: reset in any state, including mid-ACCESS, forces reset values at that edge. A write in ACCESS whose ending edge has reset=1 must not be issued, so MemWrite is gated by !reset combinationally. No response is produced for an aborted request.
- Address width: no truncation. The full ADDR_W address is passed through; memory decodes the index.

Test Plan:
- Port 0 write addr=8 data=12345, then read addr=8.
  - Required: req0_ready 1 cycle; MemWrite 1 cycle with mem_addr=8.
  - rsp0_valid 2 cycles after each handshake; read rsp0_rdata=12345; rsp1_valid never asserted.
- Port 1 write addr=16 data=98765 then read 16; also read unwritten addr=24.
  - Required: rsp1_rdata=98765, then 0; err=0.
- Both ports continuously valid reading addr 8 (port 0) / 16 (port 1), RR_EN=1.
  - Required: grants alternate 0,1,0,1.
  - A response arrives every 2 cycles, alternating ports, with correct data.
- Same stimulus with RR_EN=0.
  - Required: port 0 granted every transaction; port 1 only after req0_valid drops.
- Port 0 read addr=12.
  - Required: MemRead never asserted; rsp0_valid with rsp0_err=1, rsp0_rdata=0.
- Port 0 write addr=32 data=77 with reset asserted during ACCESS; then read addr=32.
  - Required: no MemWrite; no rsp0_valid for the write; all outputs at reset values; read returns 0.
